spi_transaction_controller: RTL and testbench
=============================================

Name: spi_transaction_controller

Overview:
- Sequences one ADS131A0X SPI word transfer: SPI mode 1 (CPOL=0, CPHA=1), MSB first.
- Drives the 3-bit state_machine code that gates the SCLK generator, which sits directly downstream.
- Consumes the generator's SPI_SCLK to shift MOSI out and sample MISO in.
- Owns SPI_CS_N and a start/done handshake to the host-side command logic.

Parameters:
- WORD_BITS, 24, bits per transaction (legal 8..32).
- CS_SETUP_CYCLES, 4, system_clock cycles CS_N is low before SCLK is enabled (>=1).
- CS_HOLD_CYCLES, 4, system_clock cycles CS_N stays low after the last SCLK fall (>=1).

Ports:
- system_clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- tx_word  in  WORD_BITS  word to send; captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; rx_word is valid from this cycle.
- rx_word  out  WORD_BITS  last received word; held until the next done.
- state_machine  out  3  state code to the SCLK generator.
- SPI_SCLK  in  1  from the generator; same clock domain, no synchroniser.
- SPI_CS_N  out  1  chip select, active low.
- SPI_MOSI  out  1  serial data to the ADC.
- SPI_MISO  in  1  serial data from the ADC.

Behaviour:
- State codes are fixed, since the generator decodes 3'd6:
  - IDLE=0, CS_SETUP=1, CS_HOLD=2, DONE=3, TRANSACTION_IN_PROGRESS=6.
  - Codes 4, 5 and 7 are unused and recover to IDLE.
- All outputs are registered. Reset values: state_machine=0, SPI_CS_N=1, SPI_MOSI=0, busy=0, done=0, rx_word=0, counters=0.
- IDLE:
  - If start=1: capture tx_word into the TX shift register, go to CS_SETUP, SPI_CS_N<=0.
  - Otherwise stay; SPI_CS_N=1.
- CS_SETUP: count CS_SETUP_CYCLES cycles, then go to TRANSACTION_IN_PROGRESS.
- Edge detect: sclk_q registers SPI_SCLK; rise = SPI_SCLK & ~sclk_q; fall = ~SPI_SCLK & sclk_q.
- TRANSACTION_IN_PROGRESS:
  - On rise: SPI_MOSI<=TX MSB; shift TX left by 1.
  - On fall: RX shift register <= {RX[WORD_BITS-2:0], SPI_MISO}; bit_cnt+1.
  - On the fall that makes bit_cnt==WORD_BITS: go to CS_HOLD in the same cycle.
  - Rise and fall never coincide.
- CS_HOLD: SPI_MOSI<=0; SPI_CS_N stays 0; count CS_HOLD_CYCLES cycles, then go to DONE.
- DONE (exactly one cycle):
  - SPI_CS_N<=1, done=1, rx_word<=RX shift register, bit_cnt<=0.
  - Next state is IDLE; start is ignored in DONE.
- start outside IDLE is ignored. tx_word changes after acceptance have no effect.
- Minimum CS_N high time between back-to-back transfers: 2 cycles (DONE + IDLE).
- SPI_SCLK is 0 on entry to state 6 because the generator forces it low outside state 6. The first edge seen is therefore always a rise.
- Timing with the current generator (half-period of 7 system_clock cycles):
  - If start is accepted at edge E0, state is 6 after edge E0+CS_SETUP_CYCLES.
  - First SCLK rise follows edge E0+CS_SETUP_CYCLES+7.
  - done is high in the cycle after edge E0+CS_SETUP_CYCLES+14*WORD_BITS+1+CS_HOLD_CYCLES. With defaults this is 345.
- Reset mid-operation: immediately SPI_CS_N=1, state_machine=0, so SCLK stops. Partial data is discarded, rx_word=0, and no done pulse is issued.

Decomposition:
- Package ads131_spi_pkg:
  - State code localparams ST_IDLE, ST_CS_SETUP, ST_CS_HOLD, ST_DONE, ST_TRANSACTION_IN_PROGRESS=3'd6.
  - SCLK_HALF_PERIOD=7, shared with the generator's divider compare.
- One sub-module, sclk_edge_detect: registers SPI_SCLK and outputs the rise/fall pulses.
- The FSM, counters and shift registers stay in the top module.

Test Plan:
- Loopback: MOSI tied to MISO, start with tx_word=24'hA5F00F -> done one cycle, rx_word=24'hA5F00F; the MOSI bit sequence on SCLK rises is MSB first.
- Timing: same run -> CS_N falls 1 cycle after start is accepted; first SCLK rise at 11 cycles; exactly 24 SCLK rises; done at cycle 345; CS_N high again on done.
- MISO held at 1 -> rx_word=24'hFFFFFF. MISO held at 0 -> rx_word=24'h000000.
- start pulsed at cycle 100 of an active transfer -> ignored; exactly one done; busy stays 1 until done.
- start held at 1 continuously -> transfers run back to back; CS_N high for exactly 2 cycles between them; second rx_word is correct.
- reset_n low at cycle 150 of a transfer -> same cycle CS_N=1, state_machine=0, SCLK stays 0, no done; a fresh transfer after release completes normally.

Source files
------------

// File: rtl/ads131_spi_pkg.sv
// ADS131A0x SPI transaction controller: shared state codes and timing.
// State codes are decoded by the downstream SCLK generator (3'd6 = run).
package ads131_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE                    = 3'd0,
    ST_CS_SETUP                = 3'd1,
    ST_CS_HOLD                 = 3'd2,
    ST_DONE                    = 3'd3,
    ST_TRANSACTION_IN_PROGRESS = 3'd6
  } state_e;

  // Generator divider compare; SCLK toggles every this many clocks.
  localparam int SCLK_HALF_PERIOD = 7;

endpackage

// File: rtl/sclk_edge_detect.sv
// Registers SPI_SCLK and flags its rising/falling edges (same clock domain).
// Ports: i_clk, i_rst_n, i_sclk -> o_rise, o_fall (combinational pulses).
module sclk_edge_detect
  import ads131_spi_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  output logic o_rise,
  output logic o_fall
);

  logic r_sclk_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sclk_q <= 1'b0;
    else          r_sclk_q <= i_sclk;
  end

  assign o_rise = i_sclk & ~r_sclk_q;
  assign o_fall = ~i_sclk & r_sclk_q;

endmodule

// File: rtl/spi_transaction_controller.sv
// Sequences one ADS131A0x SPI word (mode 1, MSB first) with CS setup/hold.
// Ports: start/tx_word in, busy/done/rx_word out, state_machine to SCLK gen,
// SPI_SCLK in from gen, SPI_CS_N/SPI_MOSI out, SPI_MISO in.
module spi_transaction_controller
  import ads131_spi_pkg::*;
#(
  parameter int WORD_BITS       = 24,
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] tx_word,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rx_word,
  output logic [2:0]           state_machine,
  input  logic                 SPI_SCLK,
  output logic                 SPI_CS_N,
  output logic                 SPI_MOSI,
  input  logic                 SPI_MISO
);

  localparam int CS_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ?
                          CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int CNT_W  = $clog2(CS_MAX + 1);
  localparam int BIT_W  = $clog2(WORD_BITS + 1);

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
  logic [WORD_BITS-1:0] r_tx, w_tx_nxt;
  logic [WORD_BITS-1:0] r_rx, w_rx_nxt;
  logic [WORD_BITS-1:0] r_rx_word, w_rx_word_nxt;
  logic                 r_cs_n, w_cs_n_nxt;
  logic                 r_mosi, w_mosi_nxt;
  logic                 r_done, r_busy;
  logic                 w_rise, w_fall;

  sclk_edge_detect u_edge (
    .i_clk   (system_clock),
    .i_rst_n (reset_n),
    .i_sclk  (SPI_SCLK),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_word <= '0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_word <= w_rx_word_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_mosi    <= w_mosi_nxt;
      // Flag the DONE cycle itself, so done and rx_word appear together.
      r_done    <= (w_state_nxt == ST_DONE);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_word_nxt = r_rx_word;
    w_cs_n_nxt    = r_cs_n;
    w_mosi_nxt    = r_mosi;
    unique case (r_state)
      ST_IDLE: begin
        w_cs_n_nxt = 1'b1;
        if (start) begin
          w_tx_nxt    = tx_word;
          w_cnt_nxt   = '0;
          w_cs_n_nxt  = 1'b0;
          w_state_nxt = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (r_cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_TRANSACTION_IN_PROGRESS;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_TRANSACTION_IN_PROGRESS: begin
        if (w_rise) begin
          w_mosi_nxt = r_tx[WORD_BITS-1];
          w_tx_nxt   = r_tx << 1;
        end else if (w_fall) begin
          w_rx_nxt  = {r_rx[WORD_BITS-2:0], SPI_MISO};
          w_bit_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == BIT_W'(WORD_BITS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_CS_HOLD;
          end
        end
      end
      ST_CS_HOLD: begin
        w_mosi_nxt = 1'b0;
        if (r_cnt == CNT_W'(CS_HOLD_CYCLES - 1)) begin
          w_cnt_nxt     = '0;
          w_cs_n_nxt    = 1'b1;
          w_rx_word_nxt = r_rx;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_bit_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_cs_n_nxt  = 1'b1;
        w_mosi_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign state_machine = r_state;
  assign busy          = r_busy;
  assign done          = r_done;
  assign rx_word       = r_rx_word;
  assign SPI_CS_N      = r_cs_n;
  assign SPI_MOSI      = r_mosi;

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Bench for spi_transaction_controller with an SCLK generator and ADC model.
// Random and directed transfers checked against a word-level reference.
module tb_spi_transaction_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] tx_word = '0;
  logic        busy, done;
  logic [23:0] rx_word;
  logic [2:0]  state_machine;
  logic        sclk = 1'b0;
  logic        cs_n, mosi, miso;

  int          mode = 0;
  logic [23:0] adc_word = '0;
  logic        adc_bit = 1'b0;
  int          adc_k = 0;
  int          rises = 0;
  logic [23:0] mosi_cap = '0;
  int          gcnt = 0;
  int          checks = 0;
  int          fails = 0;

  spi_transaction_controller dut (
    .system_clock  (clk),
    .reset_n       (reset_n),
    .start         (start),
    .tx_word       (tx_word),
    .busy          (busy),
    .done          (done),
    .rx_word       (rx_word),
    .state_machine (state_machine),
    .SPI_SCLK      (sclk),
    .SPI_CS_N      (cs_n),
    .SPI_MOSI      (mosi),
    .SPI_MISO      (miso)
  );

  always #5 clk = ~clk;

  // SCLK generator: low outside state 6, toggles every 7 clocks inside.
  always @(posedge clk) begin
    if (state_machine != 3'd6) begin
      gcnt <= 0;
      sclk <= 1'b0;
    end else if (gcnt == 6) begin
      gcnt <= 0;
      sclk <= ~sclk;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  // ADC model: drives its word MSB first on rises, samples MOSI on falls.
  always @(posedge sclk) begin
    if (adc_k < 24) adc_bit = adc_word[23 - adc_k];
    adc_k++;
    rises++;
  end

  always @(negedge sclk) mosi_cap = {mosi_cap[22:0], mosi};

  assign miso = (mode == 0) ? mosi :
                (mode == 1) ? 1'b1 :
                (mode == 2) ? 1'b0 : adc_bit;

  function automatic logic [23:0] exp_rx(input int md,
                                         input logic [23:0] tx,
                                         input logic [23:0] aw);
    case (md)
      0:       return tx;
      1:       return 24'hFFFFFF;
      2:       return 24'h000000;
      default: return aw;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [23:0] tx, input int md,
                      input logic [23:0] aw, input bit mid);
    int e, first, idle_b, nd;
    @(negedge clk);
    chk("cs_idle", 32'(cs_n), 32'd1);
    tx_word = tx; mode = md; adc_word = aw;
    adc_k = 0; rises = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tx_word = 24'($urandom);
    chk("cs_fall", 32'(cs_n), 32'd0);
    e = 0; first = -1; idle_b = 0;
    while (e < 1000) begin
      if (done) break;
      if (first < 0 && sclk) first = e;
      if (!busy) idle_b++;
      if (mid) start = (e == 100);
      @(posedge clk); #1; e++;
    end
    start = 1'b0;
    chk("done_time", 32'(e), 32'd345);
    chk("first_rise", 32'(first), 32'd11);
    chk("rises", 32'(rises), 32'd24);
    chk("rx_word", 32'(rx_word), 32'(exp_rx(md, tx, aw)));
    chk("mosi_seq", 32'(mosi_cap), 32'(tx));
    chk("cs_at_done", 32'(cs_n), 32'd1);
    chk("busy_gap", 32'(idle_b), 32'd0);
    @(posedge clk); #1;
    chk("done_1cyc", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);
    if (mid) begin
      nd = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || busy) nd++;
      end
      chk("mid_no_extra", 32'(nd), 32'd0);
    end
  endtask

  initial begin
    int e, hi, nd, sc;
    logic [23:0] t2;
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, hi, nd, sc;
    logic [23:0] t1, t2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_machine), 32'd0);
    chk("rst_cs", 32'(cs_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(rx_word), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    xfer(24'hA5F00F, 0, 24'h0, 1'b0);
    xfer(24'h5A0FF0, 1, 24'h0, 1'b0);
    xfer(24'h123456, 2, 24'h0, 1'b0);
    xfer(24'hC3C3C3, 0, 24'h0, 1'b1);
    for (int i = 0; i < 6; i++)
      xfer(24'($urandom), int'($urandom_range(0, 3)),
           24'($urandom), 1'b0);

    // Back-to-back with start held high.
    t1 = 24'h3C5A96; t2 = 24'h12EDC3;
    @(negedge clk);
    tx_word = t1; mode = 0; rises = 0; start = 1'b1;
    @(posedge clk); #1;
    e = 0;
    while (e < 1000 && !done) begin
      @(posedge clk); #1; e++;
    end
    chk("b2b_done1", 32'(e), 32'd345);
    chk("b2b_rx1", 32'(rx_word), 32'(t1));
    tx_word = t2;
    hi = 0; e = 0;
    while (cs_n && hi < 10) begin
      hi++;
      @(posedge clk); #1; e++;
    end
    chk("b2b_cs_hi", 32'(hi), 32'd2);
    while (e < 1000 && !done) begin
      @(posedge clk); #1; e++;
    end
    start = 1'b0;
    chk("b2b_gap", 32'(e), 32'd347);
    chk("b2b_rx2", 32'(rx_word), 32'(t2));
    chk("b2b_mosi2", 32'(mosi_cap), 32'(t2));
    repeat (3) @(posedge clk);

    // Reset in the middle of a transfer.
    @(negedge clk);
    tx_word = 24'($urandom); mode = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_cs", 32'(cs_n), 32'd1);
    chk("mrst_state", 32'(state_machine), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rx", 32'(rx_word), 32'd0);
    nd = 0; sc = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (sclk) sc++;
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (sclk) sc++;
    end
    chk("mrst_sclk", 32'(sc), 32'd0);
    chk("mrst_no_done", 32'(nd), 32'd0);
    xfer(24'h0F1E2D, 3, 24'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
